// File: rtl/alu_cmd_pkg.sv
// Shared widths and FSM encoding for the ALU command front-end.
package alu_cmd_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int FLAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_stats.sv
// Status counters for alu_cmd_ctrl: sticky OR of captured flags and a wrapping op counter.
module alu_cmd_stats
    import alu_cmd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [FLAG_W-1:0] flag,
    input  logic              clr,
    output logic [FLAG_W-1:0] sticky_flag,
    output logic [CNT_W-1:0]  op_count
);

    // Clear takes effect before a same-cycle capture, so the capture survives.
    logic [FLAG_W-1:0] sticky_base;
    assign sticky_base = clr ? '0 : sticky_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flag <= '0;
            op_count    <= '0;
        end else begin
            sticky_flag <= capture ? (sticky_base | flag) : sticky_base;
            if (capture) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Valid/ready command front-end for the 8-bit combinational ALU.
// Optional feature: define ALU_CMD_CHAIN_EN to add cmd_chain (reuse last result as A).
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
`ifdef ALU_CMD_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_out,
    output logic [FLAG_W-1:0] rsp_flag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic [FLAG_W-1:0] sticky_flag,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    logic              handoff;
    logic              accept;
    logic              capture;
    logic [DATA_W-1:0] next_a;

    // A new command may ride on the same edge that hands off the held result.
    assign handoff   = (state == RESP) && rsp_ready;
    assign cmd_ready = (state == IDLE) || handoff;
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state == EXEC);
    assign rsp_valid = (state == RESP);

`ifdef ALU_CMD_CHAIN_EN
    // rsp_out is the last captured result, including the one being handed off now.
    assign next_a = cmd_chain ? rsp_out : cmd_a;
`else
    assign next_a = cmd_a;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_out  <= '0;
            rsp_flag <= '0;
        end else begin
            unique case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (handoff) state <= accept ? EXEC : IDLE;
                default: state <= IDLE;
            endcase

            if (accept) begin
                alu_a   <= next_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_sel;
            end

            if (capture) begin
                rsp_out  <= alu_out;
                rsp_flag <= alu_flag;
            end
        end
    end

    alu_cmd_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .flag       (alu_flag),
        .clr        (sticky_clr),
        .sticky_flag(sticky_flag),
        .op_count   (op_count)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with an XOR ALU stub (out = a ^ b, flag = sel).
module tb_alu_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_out;
    logic [3:0] rsp_flag;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic [3:0] alu_flag;
    logic [3:0] sticky_flag;
    logic       sticky_clr;
    logic [1:0] op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign alu_out  = alu_a ^ alu_b;
    assign alu_flag = alu_sel;

    alu_cmd_ctrl #(
        .CNT_W(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
`ifdef ALU_CMD_CHAIN_EN
        .cmd_chain  (cmd_chain),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_flag   (rsp_flag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_flag   (alu_flag),
        .sticky_flag(sticky_flag),
        .sticky_clr (sticky_clr),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance, then drop cmd_valid in EXEC.
    task automatic send(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic chain);
        int n;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("accept_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sel    = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_chain  = 1'b0;
        rsp_ready  = 1'b1;
        sticky_clr = 1'b0;
        step();
        step();

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_rsp_flag", rsp_flag, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_sticky", sticky_flag, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        step();

        // Single op: C1 ^ 0F = CE, flag = sel
        send(4'h3, 8'hC1, 8'h0F, 1'b0);
        check("single_exec_ready", cmd_ready, 0);
        check("single_exec_valid", rsp_valid, 0);
        check("single_alu_a", alu_a, 8'hC1);
        check("single_alu_b", alu_b, 8'h0F);
        check("single_alu_sel", alu_sel, 4'h3);
        step();
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_out", rsp_out, 8'hCE);
        check("single_rsp_flag", rsp_flag, 4'h3);
        check("single_op_count", op_count, 1);
        step();
        check("single_done", rsp_valid, 0);

        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_alone", sticky_flag, 0);

        // Backpressure: result and operands hold, next command waits
        rsp_ready = 1'b0;
        send(4'h1, 8'h11, 8'h22, 1'b0);
        step();
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_out", rsp_out, 8'h33);
        check("bp_op_count", op_count, 2);
        check("bp_sticky", sticky_flag, 4'h1);
        cmd_valid = 1'b1;
        cmd_sel   = 4'h4;
        cmd_a     = 8'hA5;
        cmd_b     = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_hold_out", rsp_out, 8'h33);
            check("bp_hold_alu_a", alu_a, 8'h11);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("b2b_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("b2b_exec_valid", rsp_valid, 0);
        check("b2b_alu_a", alu_a, 8'hA5);
        check("b2b_alu_sel", alu_sel, 4'h4);
        step();
        check("b2b_rsp_out", rsp_out, 8'hFF);
        check("b2b_rsp_flag", rsp_flag, 4'h4);
        check("b2b_op_count", op_count, 3);
        check("sticky_or", sticky_flag, 4'h5);
        step();

        // Clear coincident with capture keeps only the new flag; counter wraps 3 -> 0
        send(4'h8, 8'h01, 8'h02, 1'b0);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("clr_capture", sticky_flag, 4'h8);
        check("wrap_zero", op_count, 0);
        check("clr_rsp_out", rsp_out, 8'h03);
        step();
        send(4'h0, 8'hFF, 8'hFF, 1'b0);
        step();
        check("wrap_one", op_count, 1);
        check("zero_out", rsp_out, 8'h00);
        check("sticky_after_zero", sticky_flag, 4'h8);
        step();

        // Reset asserted during EXEC
        send(4'hF, 8'h12, 8'h34, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_sel", alu_sel, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_sticky", sticky_flag, 0);
        check("mid_rst_out", rsp_out, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("post_rst_count", op_count, 0);

`ifdef ALU_CMD_CHAIN_EN
        send(4'h2, 8'hF0, 8'h0F, 1'b0);
        step();
        check("chain_first", rsp_out, 8'hFF);
        step();
        send(4'h2, 8'h00, 8'h0F, 1'b1);
        check("chain_alu_a", alu_a, 8'hFF);
        step();
        check("chain_rsp_out", rsp_out, 8'hF0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
